game_flow_sequencer: RTL and testbench
======================================

Name: game_flow_sequencer

Overview:
- Frame-synchronous game sequencer that drives the 8-bit game_info_reg and the randomized_value bus into the video game controller datapath.
- It consumes that datapath's collision_detect flag.
- It generates a per-game datapath reset, so a new game starts without a global reset.
- It sits between the debounced board buttons and the video game controller, and counts score in frames survived.

Parameters:
- COUNTDOWN_FRAMES, 180, frames held in COUNTDOWN before play starts (min 1).
- LEVEL_UP_FRAMES, 1800, score at which the fast-level bit is set.
- CRASH_FRAMES, 120, frames held in CRASH before OVER (min 1).
- LFSR_SEED, 8'h5A, nonzero reset value of the random generator.

Ports:
- clock  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous active-high reset
- Pixel_row  in  10  current pixel row from the VGA timing block
- Pixel_column  in  10  current pixel column from the VGA timing block
- btn_left  in  1  debounced, level
- btn_right  in  1  debounced, level
- btn_start  in  1  debounced, level
- icon_sel  in  2  player icon choice from switches
- collision_detect  in  1  sticky collision flag from the datapath
- game_rst  out  1  active-high synchronous reset to the datapath
- game_info_reg  out  8  [1:0] move (10 left, 01 right, 00 none), [3:2] tied 0, [4] fast level, [6:5] icon, [7] game over
- randomized_value  out  8  LFSR output
- score  out  16  frames survived, saturating
- state_dbg  out  3  current state encoding

Behaviour:
- Clock/reset is fixed: one clock named clock; rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - state IDLE
  - game_rst 1
  - game_info_reg 8'h00
  - score 0
  - randomized_value LFSR_SEED
  - frame counter 0
- frame_start:
  - A 1-cycle pulse on the first cycle where Pixel_row==0 and Pixel_column==0.
  - Generated by a registered compare plus rising-edge detect, so it fires once per frame even if the coords dwell at zero.
- start_edge: registered rising edge of btn_start.
- States: IDLE=0, COUNTDOWN=1, PLAY=2, CRASH=3, OVER=4.
- IDLE:
  - game_rst=1, game_info_reg=0.
  - On start_edge: latch icon_sel into [6:5], load frame counter with COUNTDOWN_FRAMES, clear score, go to COUNTDOWN.
- COUNTDOWN:
  - game_rst=0, move=00.
  - Counter decrements on each frame_start.
  - On frame_start with counter==1, go to PLAY.
- PLAY:
  - move is updated only on frame_start: 10 if only btn_left, 01 if only btn_right, otherwise 00. This matches the datapath sampling at (0,0).
  - score increments on each frame_start and saturates at 16'hFFFF.
  - [4] is set the cycle score reaches LEVEL_UP_FRAMES and stays set until the next game.
  - collision_detect==1 goes to CRASH and loads the counter with CRASH_FRAMES.
  - If collision and frame_start occur in the same cycle, collision wins and score is not incremented.
- CRASH:
  - move=00, score frozen.
  - Counter decrements on frame_start; at 1, go to OVER.
- OVER:
  - [7]=1, score held.
  - On start_edge: game_rst pulses high for exactly 1 cycle, [7] and [4] clear, icon is re-latched, score clears, counter loads COUNTDOWN_FRAMES, go to COUNTDOWN.
- start_edge is ignored in COUNTDOWN, PLAY and CRASH.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances every clock in every state.
  - If it ever reaches 0, the next value is LFSR_SEED.
- rst mid-game returns every output to its reset value on the next edge, regardless of state.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro GAME_HISCORE_EN.
- Defined:
  - Adds output hiscore[15:0], reset 0.
  - On the cycle of the CRASH->OVER transition, hiscore <= max(hiscore, score).
  - hiscore survives game_rst and is cleared only by rst.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package game_pkg holds:
  - state encodings
  - game_info_reg bit positions (MOVE_LSB=0, LEVEL_BIT=4, ICON_LSB=5, OVER_BIT=7)
  - move codes MOVE_LEFT=2'b10, MOVE_RIGHT=2'b01, MOVE_NONE=2'b00
  - LFSR tap mask
- One natural sub-module: game_lfsr8 (clock, rst, seed, value). Everything else lives in the top.

Test Plan:
- Reset then start: rst 2 cycles; pulse btn_start; COUNTDOWN_FRAMES=3 -> game_rst falls the cycle after start_edge, state goes to PLAY on the 3rd frame_start, score=0 at PLAY entry.
- Steering: in PLAY hold btn_left 2 frames, then both buttons -> game_info_reg[1:0] reads 10 after the first frame_start, then 00. The value never changes mid-frame.
- Level-up: LEVEL_UP_FRAMES=5, no collision -> score reaches 5 on the 5th PLAY frame_start, [4] goes to 1 that cycle and remains 1 at score 6.
- Collision race: assert collision_detect on the same cycle as frame_start at score=7 -> score stays 7, state CRASH; after CRASH_FRAMES=2 frame_starts, state OVER and [7]=1.
- Restart from OVER: pulse btn_start -> game_rst high exactly 1 cycle, game_info_reg[7:4]=0 except the icon, score 0, state COUNTDOWN; with GAME_HISCORE_EN, hiscore=7 persists.
- LFSR and reset: check randomized_value follows 5A, B5, 6A... per the taps for 20 cycles and is never 0. Assert rst mid-PLAY -> next edge shows IDLE, game_rst=1, score=0, game_info_reg=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the game flow sequencer.
//   - game_state_t  : sequencer state encodings (IDLE=0 .. OVER=4)
//   - game_info_reg bit positions and move codes
//   - LFSR tap mask and next-value helper for the 8-bit random generator
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_CRASH     = 3'd3,
    ST_OVER      = 3'd4
  } game_state_t;

  // game_info_reg field positions
  localparam int unsigned MOVE_LSB  = 0;
  localparam int unsigned LEVEL_BIT = 4;
  localparam int unsigned ICON_LSB  = 5;
  localparam int unsigned OVER_BIT  = 7;

  localparam logic [1:0] MOVE_LEFT  = 2'b10;
  localparam logic [1:0] MOVE_RIGHT = 2'b01;
  localparam logic [1:0] MOVE_NONE  = 2'b00;

  // Taps 8,6,5,4 (bits 7,5,4,3), XNOR feedback shifted in at bit 0.
  localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

  // The all-zero state is not a trap for XNOR feedback, but it is still
  // steered back to the seed so the sequence restarts from a known point.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur,
                                           input logic [7:0] seed);
    logic fb;
    fb = ~(^(cur & LFSR_TAP_MASK));
    if (cur == '0) begin
      lfsr_next = seed;
    end else begin
      lfsr_next = {cur[6:0], fb};
    end
  endfunction

endpackage

// File: rtl/game_lfsr8.sv
// game_lfsr8: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4).
// Ports:
//   clock  in   clock
//   rst    in   synchronous active-high reset, loads seed
//   seed   in   reset value, also the recovery value after an all-zero state
//   value  out  current register contents
module game_lfsr8
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  always_ff @(posedge clock) begin
    if (rst) begin
      value <= seed;
    end else begin
      value <= lfsr_next(value, seed);
    end
  end

endmodule

// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: frame-synchronous game flow control for the video
// game controller datapath (IDLE -> COUNTDOWN -> PLAY -> CRASH -> OVER).
// Optional feature: define GAME_HISCORE_EN to add the hiscore output.
// Ports:
//   clock            in   pixel clock
//   rst              in   synchronous active-high reset
//   Pixel_row        in   [9:0] current VGA row
//   Pixel_column     in   [9:0] current VGA column
//   btn_left         in   debounced level
//   btn_right        in   debounced level
//   btn_start        in   debounced level
//   icon_sel         in   [1:0] player icon choice
//   collision_detect in   sticky collision flag from the datapath
//   game_rst         out  per-game datapath reset (active high)
//   game_info_reg    out  [7:0] {over, icon[1:0], level, 2'b00, move[1:0]}
//   randomized_value out  [7:0] LFSR output
//   score            out  [15:0] frames survived, saturating
//   state_dbg        out  [2:0] current state encoding
//   hiscore          out  [15:0] best score (GAME_HISCORE_EN only)
module game_flow_sequencer
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned LEVEL_UP_FRAMES  = 1800,
  parameter int unsigned CRASH_FRAMES     = 120,
  parameter logic [7:0]  LFSR_SEED        = 8'h5A
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [9:0]  Pixel_row,
  input  logic [9:0]  Pixel_column,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  input  logic [1:0]  icon_sel,
  input  logic        collision_detect,
  output logic        game_rst,
  output logic [7:0]  game_info_reg,
  output logic [7:0]  randomized_value,
  output logic [15:0] score,
  output logic [2:0]  state_dbg
`ifdef GAME_HISCORE_EN
  ,
  output logic [15:0] hiscore
`endif
);

  localparam logic [15:0] CD_LOAD    = 16'(COUNTDOWN_FRAMES);
  localparam logic [15:0] CRASH_LOAD = 16'(CRASH_FRAMES);
  localparam logic [15:0] LEVEL_AT   = 16'(LEVEL_UP_FRAMES);

  game_state_t state;
  logic [15:0] frame_cnt;
  logic [1:0]  move_q;
  logic        level_q;
  logic [1:0]  icon_q;
  logic        over_q;

  logic        origin_q;
  logic        origin_q2;
  logic        frame_start;
  logic        btn_q;
  logic        start_edge;
  logic [15:0] score_inc;
  logic [1:0]  move_next;
  logic        crash_done;

  // Registered (0,0) compare; the edge detect keeps a dwell at the origin
  // from producing more than one pulse per frame.
  assign frame_start = origin_q & ~origin_q2;
  assign score_inc   = (score == '1) ? score : score + 16'd1;
  assign crash_done  = (state == ST_CRASH) && frame_start && (frame_cnt == 16'd1);
  assign state_dbg   = state;

  always_comb begin
    move_next = MOVE_NONE;
    if (btn_left && !btn_right) begin
      move_next = MOVE_LEFT;
    end else if (btn_right && !btn_left) begin
      move_next = MOVE_RIGHT;
    end
  end

  always_comb begin
    game_info_reg                   = '0;
    game_info_reg[MOVE_LSB +: 2]    = move_q;
    game_info_reg[LEVEL_BIT]        = level_q;
    game_info_reg[ICON_LSB +: 2]    = icon_q;
    game_info_reg[OVER_BIT]         = over_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= ST_IDLE;
      game_rst   <= 1'b1;
      move_q     <= MOVE_NONE;
      level_q    <= 1'b0;
      icon_q     <= '0;
      over_q     <= 1'b0;
      score      <= '0;
      frame_cnt  <= '0;
      origin_q   <= 1'b0;
      origin_q2  <= 1'b0;
      btn_q      <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      origin_q   <= (Pixel_row == '0) && (Pixel_column == '0);
      origin_q2  <= origin_q;
      btn_q      <= btn_start;
      start_edge <= btn_start & ~btn_q;

      case (state)
        ST_IDLE: begin
          game_rst <= 1'b1;
          move_q   <= MOVE_NONE;
          level_q  <= 1'b0;
          icon_q   <= '0;
          over_q   <= 1'b0;
          if (start_edge) begin
            game_rst  <= 1'b0;
            icon_q    <= icon_sel;
            frame_cnt <= CD_LOAD;
            score     <= '0;
            state     <= ST_COUNTDOWN;
          end
        end

        ST_COUNTDOWN: begin
          game_rst <= 1'b0;
          move_q   <= MOVE_NONE;
          if (frame_start) begin
            frame_cnt <= frame_cnt - 16'd1;
            if (frame_cnt == 16'd1) begin
              state <= ST_PLAY;
            end
          end
        end

        ST_PLAY: begin
          game_rst <= 1'b0;
          // Collision takes priority over a coincident frame_start.
          if (collision_detect) begin
            move_q    <= MOVE_NONE;
            frame_cnt <= CRASH_LOAD;
            state     <= ST_CRASH;
          end else if (frame_start) begin
            move_q <= move_next;
            score  <= score_inc;
            if (score_inc == LEVEL_AT) begin
              level_q <= 1'b1;
            end
          end
        end

        ST_CRASH: begin
          game_rst <= 1'b0;
          move_q   <= MOVE_NONE;
          if (frame_start) begin
            frame_cnt <= frame_cnt - 16'd1;
            if (frame_cnt == 16'd1) begin
              over_q <= 1'b1;
              state  <= ST_OVER;
            end
          end
        end

        ST_OVER: begin
          game_rst <= 1'b0;
          over_q   <= 1'b1;
          if (start_edge) begin
            // Single-cycle datapath reset; COUNTDOWN drops it again.
            game_rst  <= 1'b1;
            over_q    <= 1'b0;
            level_q   <= 1'b0;
            move_q    <= MOVE_NONE;
            icon_q    <= icon_sel;
            score     <= '0;
            frame_cnt <= CD_LOAD;
            state     <= ST_COUNTDOWN;
          end
        end

        default: begin
          state    <= ST_IDLE;
          game_rst <= 1'b1;
          move_q   <= MOVE_NONE;
          level_q  <= 1'b0;
          icon_q   <= '0;
          over_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef GAME_HISCORE_EN
  // Only rst clears the best score; game_rst restarts leave it intact.
  always_ff @(posedge clock) begin
    if (rst) begin
      hiscore <= '0;
    end else if (crash_done && (score > hiscore)) begin
      hiscore <= score;
    end
  end
`endif

  game_lfsr8 u_lfsr (
    .clock (clock),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .value (randomized_value)
  );

endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb_game_flow_sequencer: directed bench for game_flow_sequencer with
// COUNTDOWN_FRAMES=3, LEVEL_UP_FRAMES=5, CRASH_FRAMES=2.
// Define GAME_HISCORE_EN to also cover the hiscore output.
module tb_game_flow_sequencer;

  logic        clock = 1'b0;
  logic        rst;
  logic [9:0]  Pixel_row;
  logic [9:0]  Pixel_column;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic [1:0]  icon_sel;
  logic        collision_detect;
  logic        game_rst;
  logic [7:0]  game_info_reg;
  logic [7:0]  randomized_value;
  logic [15:0] score;
  logic [2:0]  state_dbg;
`ifdef GAME_HISCORE_EN
  logic [15:0] hiscore;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  game_flow_sequencer #(
    .COUNTDOWN_FRAMES (3),
    .LEVEL_UP_FRAMES  (5),
    .CRASH_FRAMES     (2),
    .LFSR_SEED        (8'h5A)
  ) dut (
    .clock            (clock),
    .rst              (rst),
    .Pixel_row        (Pixel_row),
    .Pixel_column     (Pixel_column),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_start        (btn_start),
    .icon_sel         (icon_sel),
    .collision_detect (collision_detect),
    .game_rst         (game_rst),
    .game_info_reg    (game_info_reg),
    .randomized_value (randomized_value),
    .score            (score),
    .state_dbg        (state_dbg)
`ifdef GAME_HISCORE_EN
    ,
    .hiscore          (hiscore)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One origin visit: coords at (0,0) for a single cycle, then away.
  task automatic frame();
    Pixel_row    = '0;
    Pixel_column = '0;
    tick();
    Pixel_row    = 10'd5;
    Pixel_column = 10'd5;
    tick();
  endtask

  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    logic fb;
    fb = ~(v[7] ^ v[5] ^ v[4] ^ v[3]);
    if (v == 8'h00) begin
      return 8'h5A;
    end
    return {v[6:0], fb};
  endfunction

  logic [7:0] model;

  initial begin
    rst = 1'b1;
    Pixel_row = 10'd5;
    Pixel_column = 10'd5;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_start = 1'b0;
    icon_sel = 2'b10;
    collision_detect = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_state", 16'(state_dbg), 16'd0);
    check("rst_game_rst", 16'(game_rst), 16'd1);
    check("rst_info", 16'(game_info_reg), 16'h0000);
    check("rst_score", score, 16'd0);
    check("rst_lfsr", 16'(randomized_value), 16'h005A);
    rst = 1'b0;

    // LFSR sequence from the seed
    model = 8'h5A;
    for (int i = 1; i <= 20; i++) begin
      tick();
      model = lfsr_model(model);
      check("lfsr_seq", 16'(randomized_value), 16'(model));
      check("lfsr_nonzero", 16'(randomized_value != 8'h00), 16'd1);
      if (i == 1) check("lfsr_b5", 16'(randomized_value), 16'h00B5);
      if (i == 2) check("lfsr_6a", 16'(randomized_value), 16'h006A);
    end
    check("idle_hold", 16'(state_dbg), 16'd0);

    // Start from IDLE
    btn_start = 1'b1;
    tick();
    check("start_edge_state", 16'(state_dbg), 16'd0);
    check("start_edge_grst", 16'(game_rst), 16'd1);
    tick();
    btn_start = 1'b0;
    check("cd_state", 16'(state_dbg), 16'd1);
    check("cd_grst", 16'(game_rst), 16'd0);
    check("cd_info", 16'(game_info_reg), 16'h0040);

    // Dwell at the origin: must count as a single frame
    Pixel_row = '0;
    Pixel_column = '0;
    tick();
    tick();
    tick();
    Pixel_row = 10'd5;
    Pixel_column = 10'd5;
    tick();
    frame();
    check("cd_after2", 16'(state_dbg), 16'd1);
    frame();
    check("play_entry", 16'(state_dbg), 16'd2);
    check("play_score0", score, 16'd0);

    // Steering: sampled only on frame_start
    btn_left = 1'b1;
    tick();
    tick();
    check("move_midframe0", 16'(game_info_reg[1:0]), 16'd0);
    frame();
    check("move_left1", 16'(game_info_reg), 16'h0042);
    check("score1", score, 16'd1);
    frame();
    check("move_left2", 16'(game_info_reg), 16'h0042);
    btn_right = 1'b1;
    tick();
    check("move_midframe1", 16'(game_info_reg[1:0]), 16'd2);
    frame();
    check("move_both", 16'(game_info_reg), 16'h0040);
    check("score3", score, 16'd3);
    btn_left = 1'b0;
    frame();
    check("move_right", 16'(game_info_reg), 16'h0041);
    check("score4", score, 16'd4);
    btn_right = 1'b0;

    // Level-up at score 5
    frame();
    check("score5", score, 16'd5);
    check("level_set", 16'(game_info_reg), 16'h0050);
    frame();
    check("score6", score, 16'd6);
    check("level_hold", 16'(game_info_reg[4]), 16'd1);
    frame();
    check("score7", score, 16'd7);

    // Collision coincident with frame_start
    Pixel_row = '0;
    Pixel_column = '0;
    tick();
    collision_detect = 1'b1;
    Pixel_row = 10'd5;
    Pixel_column = 10'd5;
    tick();
    collision_detect = 1'b0;
    check("crash_state", 16'(state_dbg), 16'd3);
    check("crash_score", score, 16'd7);
    check("crash_move", 16'(game_info_reg[1:0]), 16'd0);

    // start ignored in CRASH
    btn_start = 1'b1;
    tick();
    tick();
    btn_start = 1'b0;
    tick();
    check("crash_ignore_start", 16'(state_dbg), 16'd3);
    frame();
    check("crash_wait", 16'(state_dbg), 16'd3);
    frame();
    check("over_state", 16'(state_dbg), 16'd4);
    check("over_info", 16'(game_info_reg), 16'h00D0);
    check("over_score", score, 16'd7);
`ifdef GAME_HISCORE_EN
    check("hiscore_over", hiscore, 16'd7);
`endif

    // Restart from OVER
    icon_sel = 2'b01;
    btn_start = 1'b1;
    tick();
    check("restart_pre_state", 16'(state_dbg), 16'd4);
    check("restart_pre_grst", 16'(game_rst), 16'd0);
    tick();
    btn_start = 1'b0;
    check("restart_state", 16'(state_dbg), 16'd1);
    check("restart_grst", 16'(game_rst), 16'd1);
    check("restart_info", 16'(game_info_reg), 16'h0020);
    check("restart_score", score, 16'd0);
    tick();
    check("restart_grst_pulse", 16'(game_rst), 16'd0);
`ifdef GAME_HISCORE_EN
    check("hiscore_keep", hiscore, 16'd7);
`endif

    // Back into PLAY, then rst mid-game
    frame();
    frame();
    frame();
    check("play2_entry", 16'(state_dbg), 16'd2);
    frame();
    check("play2_score", score, 16'd1);
    rst = 1'b1;
    tick();
    check("midrst_state", 16'(state_dbg), 16'd0);
    check("midrst_grst", 16'(game_rst), 16'd1);
    check("midrst_score", score, 16'd0);
    check("midrst_info", 16'(game_info_reg), 16'h0000);
    check("midrst_lfsr", 16'(randomized_value), 16'h005A);
`ifdef GAME_HISCORE_EN
    check("midrst_hiscore", hiscore, 16'd0);
`endif
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
